// File: rtl/rv_scoreboard.sv
// Per-register outstanding-write scoreboard that stalls ID on RAW/WAW hazards against in-flight writes.
// Optional `SB_WB_BYPASS_EN: a retire/kill in the current cycle is subtracted before the ID hazard checks.
module rv_scoreboard #(
   parameter int MAX_OUT = 3
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_sb_issue_valid,
   input  logic        i_sb_issue_wen,
   input  logic [4:0]  i_sb_issue_rd,
   input  logic [1:0]  i_sb_rs_used,
   input  logic [4:0]  i_sb_rs1,
   input  logic [4:0]  i_sb_rs2,
   input  logic        i_sb_wb_valid,
   input  logic [4:0]  i_sb_wb_rd,
   input  logic        i_sb_kill_valid,
   input  logic [4:0]  i_sb_kill_rd,
   output logic        o_sb_stall_id,
   output logic [31:0] o_sb_busy_vec,
   output logic        o_sb_empty,
   output logic        o_sb_err
);

   localparam int CW = $clog2(MAX_OUT + 1);
   localparam logic [CW-1:0] MAX_C = CW'(MAX_OUT);

   logic [CW-1:0] cnt_q [32];
   logic [CW-1:0] cnt_d [32];
   logic [CW-1:0] eff   [32];
   logic [31:0]   busy_q, busy_d;
   logic          empty_q, empty_d;
   logic          err_q, err_d;
   logic [31:0]   wb_dec, kill_dec;
   logic          stall;
   logic          inc;

   function automatic logic [1:0] dec_amt(input logic wb, input logic kill);
      return {1'b0, wb} + {1'b0, kill};
   endfunction

   // Subtract with a floor at zero; an excess decrement is an underflow.
   function automatic logic [CW-1:0] sat_sub(input logic [CW-1:0] a, input logic [1:0] d);
      if (int'(d) > int'(a)) return '0;
      return a - CW'(d);
   endfunction

   always_comb begin
      wb_dec   = '0;
      kill_dec = '0;
      if (i_sb_wb_valid && (i_sb_wb_rd != 5'd0))     wb_dec[i_sb_wb_rd]     = 1'b1;
      if (i_sb_kill_valid && (i_sb_kill_rd != 5'd0)) kill_dec[i_sb_kill_rd] = 1'b1;
      for (int r = 0; r < 32; r++) begin
`ifdef SB_WB_BYPASS_EN
         eff[r] = sat_sub(cnt_q[r], dec_amt(wb_dec[r], kill_dec[r]));
`else
         eff[r] = cnt_q[r];
`endif
      end
   end

   // Stall is independent of inc, so no loop through the issue qualifier.
   always_comb begin
      stall = (i_sb_rs_used[0] && (i_sb_rs1 != 5'd0) && (eff[i_sb_rs1] != '0))
            | (i_sb_rs_used[1] && (i_sb_rs2 != 5'd0) && (eff[i_sb_rs2] != '0))
            | (i_sb_issue_valid && i_sb_issue_wen && (i_sb_issue_rd != 5'd0)
               && (eff[i_sb_issue_rd] == MAX_C));
   end

   assign o_sb_stall_id = stall;

   always_comb begin
      inc     = i_sb_issue_valid && i_sb_issue_wen && !stall && (i_sb_issue_rd != 5'd0);
      err_d   = err_q;
      busy_d  = '0;
      cnt_d[0] = '0;
      for (int r = 1; r < 32; r++) begin
         if (int'(dec_amt(wb_dec[r], kill_dec[r])) > int'(cnt_q[r])) err_d = 1'b1;
         cnt_d[r] = sat_sub(cnt_q[r], dec_amt(wb_dec[r], kill_dec[r]))
                  + CW'(inc && (i_sb_issue_rd == 5'(r)));
         busy_d[r] = (cnt_d[r] != '0);
      end
      empty_d = (busy_d == '0);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
         busy_q  <= '0;
         empty_q <= 1'b1;
         err_q   <= 1'b0;
      end else begin
         for (int r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
         busy_q  <= busy_d;
         empty_q <= empty_d;
         err_q   <= err_d;
      end
   end

   assign o_sb_busy_vec = busy_q;
   assign o_sb_empty    = empty_q;
   assign o_sb_err      = err_q;

endmodule

// File: tb/tb_rv_scoreboard.sv
// Directed bench for rv_scoreboard (MAX_OUT=3); expectations follow SB_WB_BYPASS_EN when defined.
module tb_rv_scoreboard;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        issue_valid, issue_wen;
   logic [4:0]  issue_rd;
   logic [1:0]  rs_used;
   logic [4:0]  rs1, rs2;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic        kill_valid;
   logic [4:0]  kill_rd;
   logic        stall_id;
   logic [31:0] busy_vec;
   logic        empty;
   logic        err;

   int total = 0;
   int bad   = 0;

`ifdef SB_WB_BYPASS_EN
   localparam logic BYP = 1'b1;
`else
   localparam logic BYP = 1'b0;
`endif

   rv_scoreboard #(.MAX_OUT(3)) dut (
      .i_clk            (clk),
      .i_rst_n          (rst_n),
      .i_sb_issue_valid (issue_valid),
      .i_sb_issue_wen   (issue_wen),
      .i_sb_issue_rd    (issue_rd),
      .i_sb_rs_used     (rs_used),
      .i_sb_rs1         (rs1),
      .i_sb_rs2         (rs2),
      .i_sb_wb_valid    (wb_valid),
      .i_sb_wb_rd       (wb_rd),
      .i_sb_kill_valid  (kill_valid),
      .i_sb_kill_rd     (kill_rd),
      .o_sb_stall_id    (stall_id),
      .o_sb_busy_vec    (busy_vec),
      .o_sb_empty       (empty),
      .o_sb_err         (err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      issue_valid = 1'b0; issue_wen = 1'b0; issue_rd = 5'd0;
      rs_used = 2'b00; rs1 = 5'd0; rs2 = 5'd0;
      wb_valid = 1'b0; wb_rd = 5'd0; kill_valid = 1'b0; kill_rd = 5'd0;
   endtask

   task automatic issue(input logic [4:0] rd);
      issue_valid = 1'b1; issue_wen = 1'b1; issue_rd = rd;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      idle();
      rst_n = 1'b0;
      rs_used = 2'b11; rs1 = 5'd5; rs2 = 5'd5;
      tick(); tick();
      #2;
      chk("t1_busy",  busy_vec, 32'h0);
      chk("t1_empty", {31'b0, empty}, 32'd1);
      chk("t1_err",   {31'b0, err}, 32'd0);
      chk("t1_stall", {31'b0, stall_id}, 32'd0);
      rst_n = 1'b1;
      idle();
      tick();

      // T2: RAW on x5 via rs1 then rs2, released by a WB retire
      issue(5'd5);
      #2 chk("t2_issue_stall", {31'b0, stall_id}, 32'd0);
      tick();
      idle(); rs_used = 2'b01; rs1 = 5'd5;
      #2 chk("t2_rs1_stall", {31'b0, stall_id}, 32'd1);
      chk("t2_busy", busy_vec, 32'h0000_0020);
      chk("t2_empty", {31'b0, empty}, 32'd0);
      tick();
      rs_used = 2'b10; rs1 = 5'd0; rs2 = 5'd5;
      #2 chk("t2_rs2_stall", {31'b0, stall_id}, 32'd1);
      tick();
      wb_valid = 1'b1; wb_rd = 5'd5;
      #2 chk("t2_wb_cycle_stall", {31'b0, stall_id}, {31'b0, ~BYP});
      tick();
      wb_valid = 1'b0;
      #2 chk("t2_after_wb_stall", {31'b0, stall_id}, 32'd0);
      chk("t2_after_wb_busy", busy_vec, 32'h0);
      chk("t2_after_wb_empty", {31'b0, empty}, 32'd1);
      idle();
      tick();

      // T3: x0 is never tracked and retiring x0 is not an underflow
      issue(5'd0); rs_used = 2'b01; rs1 = 5'd0;
      wb_valid = 1'b1; wb_rd = 5'd0; kill_valid = 1'b1; kill_rd = 5'd0;
      #2 chk("t3_stall", {31'b0, stall_id}, 32'd0);
      tick();
      idle();
      #2 chk("t3_busy", busy_vec, 32'h0);
      chk("t3_empty", {31'b0, empty}, 32'd1);
      chk("t3_err", {31'b0, err}, 32'd0);

      // T4: WAW saturation at MAX_OUT on x7
      issue(5'd7);
      for (int i = 0; i < 3; i++) begin
         #2 chk("t4_fill_stall", {31'b0, stall_id}, 32'd0);
         tick();
      end
      #2 chk("t4_full_stall", {31'b0, stall_id}, 32'd1);
      chk("t4_full_busy", busy_vec, 32'h0000_0080);
      tick();
      #2 chk("t4_held_stall", {31'b0, stall_id}, 32'd1);
      issue_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd7;
      tick();
      wb_valid = 1'b0; issue(5'd7);
      #2 chk("t4_reissue_stall", {31'b0, stall_id}, 32'd0);
      tick();
      #2 chk("t4_refull_stall", {31'b0, stall_id}, 32'd1);
      issue_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd7;
      tick(); tick();
      #2 chk("t4_drain2_busy", busy_vec, 32'h0000_0080);
      tick();
      wb_valid = 1'b0;
      #2 chk("t4_drain3_busy", busy_vec, 32'h0);
      chk("t4_empty", {31'b0, empty}, 32'd1);
      chk("t4_err", {31'b0, err}, 32'd0);
      idle();

      // T5: simultaneous inc+dec, then wb+kill underflow on x9
      issue(5'd9);
      tick();
      wb_valid = 1'b1; wb_rd = 5'd9;
      #2 chk("t5_incdec_stall", {31'b0, stall_id}, 32'd0);
      tick();
      idle();
      #2 chk("t5_incdec_busy", busy_vec, 32'h0000_0200);
      chk("t5_incdec_err", {31'b0, err}, 32'd0);
      wb_valid = 1'b1; wb_rd = 5'd9; kill_valid = 1'b1; kill_rd = 5'd9;
      tick();
      idle();
      #2 chk("t5_uf_busy", busy_vec, 32'h0);
      chk("t5_uf_err", {31'b0, err}, 32'd1);
      chk("t5_uf_empty", {31'b0, empty}, 32'd1);
      tick();
      chk("t5_err_sticky", {31'b0, err}, 32'd1);

      // T6: asynchronous reset mid-run discards count[3]=2, count[12]=1
      issue(5'd3);
      tick(); tick();
      issue(5'd12);
      tick();
      idle();
      #2 chk("t6_busy", busy_vec, 32'h0000_1008);
      chk("t6_empty", {31'b0, empty}, 32'd0);
      rs_used = 2'b01; rs1 = 5'd3;
      #1 chk("t6_pre_stall", {31'b0, stall_id}, 32'd1);
      tick();
      rst_n = 1'b0;
      #2 chk("t6_rst_busy", busy_vec, 32'h0);
      chk("t6_rst_empty", {31'b0, empty}, 32'd1);
      chk("t6_rst_err", {31'b0, err}, 32'd0);
      chk("t6_rst_stall", {31'b0, stall_id}, 32'd0);
      tick();
      rst_n = 1'b1;
      idle();
      issue(5'd3);
      tick();
      idle(); wb_valid = 1'b1; wb_rd = 5'd3;
      tick();
      idle();
      #2 chk("t6_post_busy", busy_vec, 32'h0);
      chk("t6_post_err", {31'b0, err}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
